// File: rtl/maxpool_fifo_ctrl_pkg.sv
// Shared definitions for the max-pool FIFO sequencer: sequencer states,
// default geometry and the derived counter widths.
package maxpool_fifo_ctrl_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int SYSTOLIC_SIZE = 16;
  localparam int MAX_HEIGHT    = 416;

  localparam int W_BITS = $clog2(2*SYSTOLIC_SIZE+1);
  localparam int H_BITS = $clog2(MAX_HEIGHT+1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    EVEN_ROW = 3'd2,
    ODD_ROW  = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Pooling works on pixel pairs, so a trailing odd pixel or row is dropped.
  function automatic logic [W_BITS-1:0] floorEvenW(input logic [W_BITS-1:0] v);
    return {v[W_BITS-1:1], 1'b0};
  endfunction

  function automatic logic [H_BITS-1:0] floorEvenH(input logic [H_BITS-1:0] v);
    return {v[H_BITS-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/maxpool_fifo_ctrl_pos_counter.sv
// Column/row position tracker for the pooled frame. Reports column parity
// and end-of-row / end-of-frame flags so the sequencer never needs raw counts.
module pool_pos_counter
  import maxpool_fifo_ctrl_pkg::*;
#(
  parameter int WB = W_BITS,
  parameter int HB = H_BITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  input  logic [WB-1:0] i_width,
  input  logic [HB-1:0] i_height,
  output logic          o_colOdd,
  output logic          o_colLast,
  output logic          o_rowLast
);

  localparam logic [WB-1:0] ONE_W = 1;
  localparam logic [HB-1:0] ONE_H = 1;

  logic [WB-1:0] r_col;
  logic [HB-1:0] r_row;

  assign o_colOdd  = r_col[0];
  assign o_colLast = (r_col == i_width - ONE_W);
  assign o_rowLast = (r_row == i_height - ONE_H);

  // Advance one column per accepted pixel; the last column wraps and opens the next row.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_en) begin
      if (o_colLast) begin
        r_col <= '0;
        r_row <= r_row + ONE_H;
      end else begin
        r_col <= r_col + ONE_W;
      end
    end
  end

endmodule

// File: rtl/maxpool_fifo_ctrl.sv
// Sequencer for the 2x2 stride-2 max-pool stage. Even rows push horizontal
// pair maxima into the FIFO array; odd rows pull them back for the vertical
// compare and emit one pooled vector per pixel pair. All outputs are registered.
module maxpool_fifo_ctrl
  import maxpool_fifo_ctrl_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = maxpool_fifo_ctrl_pkg::SYSTOLIC_SIZE,
  parameter int MAX_HEIGHT    = maxpool_fifo_ctrl_pkg::MAX_HEIGHT
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [$clog2(2*SYSTOLIC_SIZE+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]        cfg_height,
  input  logic                                   in_valid,
  output logic                                   fifo_rd_clr,
  output logic                                   fifo_wr_clr,
  output logic                                   fifo_rd_en,
  output logic                                   fifo_wr_en,
  output logic                                   h_load,
  output logic                                   h_cmp,
  output logic                                   v_sel,
  output logic                                   out_valid,
  output logic                                   busy,
  output logic                                   done
);

  localparam int WB = $clog2(2*SYSTOLIC_SIZE+1);
  localparam int HB = $clog2(MAX_HEIGHT+1);

  state_t        r_state;
  state_t        w_nextState;
  logic [WB-1:0] r_width;
  logic [HB-1:0] r_height;

  logic w_colOdd, w_colLast, w_rowLast, w_pixel, w_accept;
  logic w_clr, w_rdEn, w_wrEn, w_hLoad, w_hCmp, w_vSel, w_outValid, w_busy, w_done;
  logic r_clr, r_rdEn, r_wrEn, r_hLoad, r_hCmp, r_vSel, r_outValid, r_busy, r_done;

  assign w_pixel  = in_valid && (r_state == EVEN_ROW || r_state == ODD_ROW);
  assign w_accept = (r_state == IDLE) && start && !r_done;

  pool_pos_counter #(.WB(WB), .HB(HB)) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state == CLEAR),
    .i_en      (w_pixel),
    .i_width   (r_width),
    .i_height  (r_height),
    .o_colOdd  (w_colOdd),
    .o_colLast (w_colLast),
    .o_rowLast (w_rowLast)
  );

  // State register plus frame geometry, latched (floored to even) only when a start is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_width  <= '0;
      r_height <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_width  <= floorEvenW(cfg_width);
        r_height <= floorEvenH(cfg_height);
      end
    end
  end

  // Next state: rows alternate even/odd on each column wrap; the wrap of the last odd row ends the frame.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_nextState = CLEAR;
      CLEAR:    w_nextState = (r_width == '0 || r_height == '0) ? DONE : EVEN_ROW;
      EVEN_ROW: if (in_valid && w_colLast) w_nextState = ODD_ROW;
      ODD_ROW:  if (in_valid && w_colLast) w_nextState = w_rowLast ? DONE : EVEN_ROW;
      DONE:     w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // Strobe decode for the current cycle; registered below so the datapath sees them one cycle later.
  always_comb begin
    w_clr      = (r_state == CLEAR);
    w_busy     = (r_state == CLEAR || r_state == EVEN_ROW || r_state == ODD_ROW);
    w_done     = (r_state == DONE);
    w_rdEn     = 1'b0;
    w_wrEn     = 1'b0;
    w_hLoad    = 1'b0;
    w_hCmp     = 1'b0;
    w_vSel     = 1'b0;
    w_outValid = 1'b0;
    if (w_pixel) begin
      if (!w_colOdd) begin
        w_hLoad = 1'b1;
        w_rdEn  = (r_state == ODD_ROW);
      end else begin
        w_hCmp     = 1'b1;
        w_wrEn     = (r_state == EVEN_ROW);
        w_vSel     = (r_state == ODD_ROW);
        w_outValid = (r_state == ODD_ROW);
      end
    end
  end

  // Output registers; reset forces every strobe low on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr      <= 1'b0;
      r_rdEn     <= 1'b0;
      r_wrEn     <= 1'b0;
      r_hLoad    <= 1'b0;
      r_hCmp     <= 1'b0;
      r_vSel     <= 1'b0;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_clr      <= w_clr;
      r_rdEn     <= w_rdEn;
      r_wrEn     <= w_wrEn;
      r_hLoad    <= w_hLoad;
      r_hCmp     <= w_hCmp;
      r_vSel     <= w_vSel;
      r_outValid <= w_outValid;
      r_busy     <= w_busy;
      r_done     <= w_done;
    end
  end

  assign fifo_rd_clr = r_clr;
  assign fifo_wr_clr = r_clr;
  assign fifo_rd_en  = r_rdEn;
  assign fifo_wr_en  = r_wrEn;
  assign h_load      = r_hLoad;
  assign h_cmp       = r_hCmp;
  assign v_sel       = r_vSel;
  assign out_valid   = r_outValid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_maxpool_fifo_ctrl.sv
// Scoreboard bench for maxpool_fifo_ctrl: the stimulus side predicts, per
// frame, which strobe pattern must appear on which cycle; an independent
// monitor checks every non-idle output cycle against that prediction.
module tb_maxpool_fifo_ctrl;
  import maxpool_fifo_ctrl_pkg::*;

  localparam logic [8:0] V_RDCLR = 9'b100000000;
  localparam logic [8:0] V_WRCLR = 9'b010000000;
  localparam logic [8:0] V_RDEN  = 9'b001000000;
  localparam logic [8:0] V_WREN  = 9'b000100000;
  localparam logic [8:0] V_HLOAD = 9'b000010000;
  localparam logic [8:0] V_HCMP  = 9'b000001000;
  localparam logic [8:0] V_VSEL  = 9'b000000100;
  localparam logic [8:0] V_OVAL  = 9'b000000010;
  localparam logic [8:0] V_DONE  = 9'b000000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W_BITS-1:0] cfg_width = '0;
  logic [H_BITS-1:0] cfg_height = '0;
  logic in_valid = 1'b0;
  logic fifo_rd_clr, fifo_wr_clr, fifo_rd_en, fifo_wr_en;
  logic h_load, h_cmp, v_sel, out_valid, busy, done;

  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   edgeCnt = 0;

  maxpool_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .in_valid    (in_valid),
    .fifo_rd_clr (fifo_rd_clr),
    .fifo_wr_clr (fifo_wr_clr),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_wr_en  (fifo_wr_en),
    .h_load      (h_load),
    .h_cmp       (h_cmp),
    .v_sel       (v_sel),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  wire [8:0] dutVec = {fifo_rd_clr, fifo_wr_clr, fifo_rd_en, fifo_wr_en,
                       h_load, h_cmp, v_sel, out_valid, done};

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Monitor: every cycle showing any strobe must match the oldest predicted entry.
  always @(negedge clk) begin
    exp_t e;
    if (dutVec != 9'd0) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_strobe cycle=%0d got=%b required=none", edgeCnt, dutVec);
      end else begin
        e = expQ.pop_front();
        if (e.cyc != edgeCnt || e.vec != dutVec) begin
          bad++;
          $display("[TB] FAIL scoreboard cycle=%0d got=%b required=%b at cycle %0d",
                   edgeCnt, dutVec, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired got=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference behaviour of one accepted pixel, from its row/column parity.
  function automatic logic [8:0] pixVec(input int r, input int c);
    if (r % 2 == 0) return (c % 2 == 0) ? V_HLOAD : (V_HCMP | V_WREN);
    return (c % 2 == 0) ? (V_HLOAD | V_RDEN) : (V_HCMP | V_VSEL | V_OVAL);
  endfunction

  // One complete frame: start, optional stalls/noise between pixels, and the
  // predicted strobe timeline pushed into the scoreboard as it is issued.
  task automatic applyStimulus(input int w, input int h, input int stallMax,
                               input bit noisy, input bit b2bStart);
    int wf, hf, e0, stalls;
    wf = w & ~1;
    hf = h & ~1;
    cfg_width  = W_BITS'(w);
    cfg_height = H_BITS'(h);
    start = 1'b1;
    step();
    start = 1'b0;
    e0 = edgeCnt;
    expQ.push_back('{e0 + 1, V_RDCLR | V_WRCLR});
    step();
    checkOutput("busy_in_clear", int'(busy), 1);
    if (wf == 0 || hf == 0) begin
      expQ.push_back('{e0 + 2, V_DONE});
      step();
      checkOutput("busy_after_zero_cfg", int'(busy), 0);
      step();
      return;
    end
    for (int r = 0; r < hf; r++) begin
      for (int c = 0; c < wf; c++) begin
        stalls = (stallMax > 0) ? int'($urandom_range(0, stallMax)) : 0;
        repeat (stalls) begin
          in_valid = 1'b0;
          start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
          if (noisy) begin
            cfg_width  = W_BITS'($urandom);
            cfg_height = H_BITS'($urandom);
          end
          step();
        end
        in_valid = 1'b1;
        start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        expQ.push_back('{edgeCnt, pixVec(r, c)});
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    expQ.push_back('{edgeCnt + 1, V_DONE});
    step();
    checkOutput("busy_at_done", int'(busy), 0);
    if (b2bStart) begin
      cfg_width  = W_BITS'(2);
      cfg_height = H_BITS'(2);
      start = 1'b1;
    end
    step();
    start = 1'b0;
    step();
  endtask

  initial begin
    int w, h;
    $display("[TB] start");
    repeat (3) step();
    checkOutput("reset_strobes", int'(dutVec), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();

    applyStimulus(4, 4, 0, 1'b0, 1'b1);
    applyStimulus(4, 4, 0, 1'b0, 1'b0);
    applyStimulus(4, 4, 3, 1'b1, 1'b0);
    applyStimulus(32, 2, 0, 1'b0, 1'b0);
    applyStimulus(33, 2, 1, 1'b0, 1'b0);
    applyStimulus(4, 0, 0, 1'b0, 1'b0);
    applyStimulus(0, 4, 0, 1'b0, 1'b0);
    applyStimulus(4, 1, 0, 1'b0, 1'b0);

    cfg_width  = W_BITS'(4);
    cfg_height = H_BITS'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    expQ.push_back('{edgeCnt + 1, V_RDCLR | V_WRCLR});
    step();
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      step();
      expQ.push_back('{edgeCnt, pixVec(c / 4, c % 4)});
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checkOutput("midreset_strobes", int'(dutVec), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();
    applyStimulus(2, 2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      w = int'($urandom_range(0, 33));
      h = int'($urandom_range(0, 9));
      applyStimulus(w, h, int'($urandom_range(0, 2)), 1'b1, 1'(k % 2));
    end

    repeat (4) step();
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
